data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter that shares the banked data memory between the CPU load/store port (port 0) and a secondary master such as DMA or an accelerator (port 1). It sits directly in front of the data memory manager and drives its address, write data, write enable and byte mode. It returns read data to whichever port issued the read. Port 0 has priority, and a bounded-starvation counter guarantees port 1 forward progress.

## Interface
Parameters:
- READ_LAT, 1: cycles from grant to read data valid on mem_rdata_i (1..4)
- MAX_BURST, 4: max consecutive port-0 grants while port 1 waits (1..15)

Ports (k = 0,1; one set per requester):
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- reqk_i  in  1  request; held with fields stable until gntk_o
- wek_i  in  1  1 = write, 0 = read
- addrk_i  in  32  byte address; bank = addr[19:18]
- wdatak_i  in  32  write data
- bmodek_i  in  32  byte mode, passed unchanged to memory
- gntk_o  out  1  combinational grant; request accepted this cycle
- rvalidk_o  out  1  one-cycle read-data-valid pulse
- rdatak_o  out  32  read data, valid only with rvalidk_o, else 0
- errk_o  out  1  one-cycle pulse: granted access with addr[31:20] != 0
- mem_addr_o  out  32  address to memory manager
- mem_data_o  out  32  write data to memory manager
- mem_wren_o  out  1  write enable to memory manager
- mem_bmode_o  out  32  byte mode to memory manager
- mem_rdata_i  in  32  read data from memory manager
- busy_o  out  1  at least one read in flight

## Operation
- At most one grant per cycle. Grant rules:
  - Only req0 asserted: grant 0.
  - Only req1 asserted: grant 1.
  - Both asserted: grant 0 unless starve_cnt == MAX_BURST, then grant 1.
- starve_cnt (4 bits):
  - +1 when both request and 0 is granted.
  - Cleared when 1 is granted or req1_i is low.
  - Saturates at MAX_BURST.
- FSM tracks the last owner: IDLE (no grant), OWN0, OWN1, updated every cycle from the grant decision. The state feeds only the debug/busy logic and a return to IDLE; arbitration uses starve_cnt.
- Granted cycle: mem_addr_o/mem_data_o/mem_bmode_o = selected port fields.
  - mem_wren_o = we of that port, forced 0 when addr[31:20] != 0 (err case).
- No grant: mem_addr_o, mem_data_o and mem_bmode_o = 0; mem_wren_o = 0.
- Reads: the grant pushes {valid, port, err} into a READ_LAT-deep tag shift register.
  - At tag exit, rvalid of the tagged port = 1.
  - rdata = mem_rdata_i, or 0 if err.
  - The other port's rdata = 0.
- Writes: no rvalid; data is committed on the grant edge.
- errk_o pulses in the grant cycle, for both reads and writes.
- busy_o = OR of tag valid bits.

## Timing
- Reset (RST high at an edge):
  - gnt*, rvalid*, err*, mem_wren_o, busy_o = 0.
  - rdata* = 0, starve_cnt = 0, FSM = IDLE.
  - All in-flight tags are cleared, so pending reads are dropped and produce no rvalid.
- Grant is combinational in cycle T. Memory samples on the T→T+1 edge.
- Read grant at T gives rvalid in cycle T+READ_LAT.
- Back-to-back: one new access per cycle sustained, with reads and writes interleaved freely.
  - Read responses return in grant order.
  - No overlap between ports is possible.
- Requests dropped before grant are legal: no state change except starve_cnt clearing when req1 drops.
- Simultaneous read-data return and new grant in the same cycle is legal and independent.
- RST asserted mid-burst: the next cycle behaves as a fresh IDLE, with no stale rvalid.

## Test plan
- Reset with reads in flight → in the cycle after RST, all outputs are 0, busy_o = 0, and no rvalid appears later.
- Port 0 reads 0x0004_0010 (bank 1) at T, memory returns 0xDEADBEEF → rvalid0_o = 1 and rdata0_o = 0xDEADBEEF at T+1; rvalid1_o stays 0.
- Both ports request continuously, MAX_BURST = 4 → grant pattern 0,0,0,0,1,0,0,0,0,1…; port 1 never waits more than 4 cycles.
- Port 1 write to 0x0008_0000 with data 0x12345678 and bmode 2 → same cycle: mem_wren_o = 1, mem_addr_o = 0x0008_0000, mem_data_o = 0x12345678, mem_bmode_o = 2; no rvalid.
- Port 0 write to 0x0010_0000 → gnt0_o = 1, err0_o = 1, mem_wren_o = 0. Port 0 read of the same address → rvalid0_o with rdata0_o = 0.
- READ_LAT = 3, alternating reads 0,1,0 at T, T+1, T+2 → rvalid pulses at T+3 (port 0), T+4 (port 1) and T+5 (port 0), each with matching data; busy_o is high T+1..T+5.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port data-memory arbiter: port 0 (CPU) has priority, port 1 gets a turn after MAX_BURST port-0 wins.
// Latency: the grant is combinational; read data returns READ_LAT cycles after the grant, in grant order.
// Backpressure: a requester holds its fields until gnt; no grant is issued while RST is high.
module data_mem_arbiter #(
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_i,
    input  logic        we0_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] bmode0_i,
    output logic        gnt0_o,
    output logic        rvalid0_o,
    output logic [31:0] rdata0_o,
    output logic        err0_o,
    input  logic        req1_i,
    input  logic        we1_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata1_i,
    input  logic [31:0] bmode1_i,
    output logic        gnt1_o,
    output logic        rvalid1_o,
    output logic [31:0] rdata1_o,
    output logic        err1_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_wren_o,
    output logic [31:0] mem_bmode_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    typedef struct packed {
        logic vld;
        logic port;
        logic err;
    } tag_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  starve_cnt;
    logic        gnt0;
    logic        gnt1;
    logic        gnt_any;
    logic        sel_we;
    logic        sel_err;
    logic [31:0] sel_addr;
    tag_t        tag_q   [READ_LAT];
    tag_t        tag_eff [READ_LAT];
    tag_t        tag_out;
    logic        busy;

    assign gnt1    = ~RST & req1_i & (~req0_i | (starve_cnt == BURST_LIM));
    assign gnt0    = ~RST & req0_i & ~gnt1;
    assign gnt_any = gnt0 | gnt1;

    assign sel_addr = gnt1 ? addr1_i : addr0_i;
    assign sel_we   = gnt1 ? we1_i   : we0_i;
    assign sel_err  = |sel_addr[31:20];

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (!req1_i || gnt1) begin
            starve_cnt <= '0;
        end else if (gnt0 && starve_cnt != BURST_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (gnt0) begin
            state_nxt = OWN0;
        end else if (gnt1) begin
            state_nxt = OWN1;
        end
    end

    // Stage 0 records what the selected port asked for; the owner state says whether it was granted.
    always_comb begin
        for (int i = 0; i < READ_LAT; i++) begin
            tag_eff[i] = tag_q[i];
        end
        tag_eff[0].vld = tag_q[0].vld & (state != IDLE);
        busy = 1'b0;
        for (int i = 0; i < READ_LAT; i++) begin
            busy = busy | tag_eff[i].vld;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < READ_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: ~sel_we, port: gnt1, err: sel_err};
            for (int i = 1; i < READ_LAT; i++) begin
                tag_q[i] <= tag_eff[i-1];
            end
        end
    end

    assign tag_out   = tag_eff[READ_LAT-1];
    assign rvalid0_o = tag_out.vld & ~tag_out.port;
    assign rvalid1_o = tag_out.vld &  tag_out.port;
    assign rdata0_o  = (rvalid0_o && !tag_out.err) ? mem_rdata_i : '0;
    assign rdata1_o  = (rvalid1_o && !tag_out.err) ? mem_rdata_i : '0;

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;
    assign err0_o = gnt0 & (|addr0_i[31:20]);
    assign err1_o = gnt1 & (|addr1_i[31:20]);

    // Out-of-range accesses still present on the bus but never write.
    assign mem_addr_o  = gnt_any ? sel_addr : '0;
    assign mem_data_o  = gnt0 ? wdata0_i : (gnt1 ? wdata1_i : '0);
    assign mem_bmode_o = gnt0 ? bmode0_i : (gnt1 ? bmode1_i : '0);
    assign mem_wren_o  = gnt_any & sel_we & ~sel_err;
    assign busy_o      = busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized scoreboard bench for data_mem_arbiter with a behavioural memory and arbitration model.
module tb_data_mem_arbiter;

    localparam int READ_LAT  = 3;
    localparam int MAX_BURST = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0_i, we0_i, req1_i, we1_i;
    logic [31:0] addr0_i, wdata0_i, bmode0_i, addr1_i, wdata1_i, bmode1_i;
    logic        gnt0_o, rvalid0_o, err0_o, gnt1_o, rvalid1_o, err1_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_bmode_o, mem_rdata_i;
    logic        mem_wren_o, busy_o;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(.READ_LAT(READ_LAT), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .RST(RST),
        .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i), .bmode0_i(bmode0_i),
        .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o), .rdata0_o(rdata0_o), .err0_o(err0_o),
        .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i), .bmode1_i(bmode1_i),
        .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o), .rdata1_o(rdata1_o), .err1_o(err1_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_wren_o(mem_wren_o),
        .mem_bmode_o(mem_bmode_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    typedef struct {
        bit          act;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bmode;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    req_t               rq [2];
    rsp_t               exp_q [$];
    rsp_t               mon_e;
    logic [31:0]        ref_mem  [logic [31:0]];
    logic [31:0]        stub_mem [logic [31:0]];
    logic [31:0]        pipe [READ_LAT];
    logic [31:0]        stub_rd;
    int                 cyc = 0;
    int                 n_chk;
    int                 n_pass;
    int                 p1_passed;
    int                 p1_wait;
    bit [READ_LAT-1:0]  hist;
    bit                 rst;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Memory manager stand-in: samples the bus on the grant edge, returns data READ_LAT cycles later.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        stub_rd = stub_mem.exists(mem_addr_o) ? stub_mem[mem_addr_o] : init_val(mem_addr_o);
        if (mem_wren_o) stub_mem[mem_addr_o] = mem_data_o;
        pipe[0] <= stub_rd;
        for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata_i = pipe[READ_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic apply();
        RST      = rst;
        req0_i   = rq[0].act;  we0_i = rq[0].we;  addr0_i = rq[0].addr;
        wdata0_i = rq[0].wdata; bmode0_i = rq[0].bmode;
        req1_i   = rq[1].act;  we1_i = rq[1].we;  addr1_i = rq[1].addr;
        wdata1_i = rq[1].wdata; bmode1_i = rq[1].bmode;
    endtask

    task automatic set_req(input int k, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] b);
        rq[k] = '{act: 1'b1, we: we, addr: a, wdata: d, bmode: b};
        if (k == 1) p1_wait = 0;
    endtask

    task automatic rand_req(input int k);
        logic [11:0] hi;
        logic [1:0]  bank;
        logic [3:0]  off;
        hi   = ($urandom_range(7) == 0) ? 12'($urandom_range(4095, 1)) : 12'h000;
        bank = 2'($urandom_range(3));
        off  = 4'($urandom_range(15));
        set_req(k, 1'($urandom_range(1)), {hi, bank, 12'h000, off, 2'b00}, $urandom,
                32'($urandom_range(15)));
    endtask

    // One cycle: drive, check same-cycle outputs against the model, advance the model on the edge.
    task automatic step();
        bit g0, g1, e0, e1, rd_g, r1_was, ew;
        int k;
        logic [31:0] ea, ed, eb;
        apply();
        #1;
        r1_was = rq[1].act;
        g1 = !rst && rq[1].act && (!rq[0].act || p1_passed == MAX_BURST);
        g0 = !rst && rq[0].act && !g1;
        e0 = g0 && (rq[0].addr[31:20] != 12'h000);
        e1 = g1 && (rq[1].addr[31:20] != 12'h000);
        chk("gnt0", 32'(gnt0_o), 32'(g0));
        chk("gnt1", 32'(gnt1_o), 32'(g1));
        chk("err0", 32'(err0_o), 32'(e0));
        chk("err1", 32'(err1_o), 32'(e1));
        chk("busy", 32'(busy_o), 32'(|hist));
        ea = '0; ed = '0; eb = '0; ew = 1'b0; rd_g = 1'b0;
        if (g0 || g1) begin
            k  = g1 ? 1 : 0;
            ea = rq[k].addr; ed = rq[k].wdata; eb = rq[k].bmode;
            ew = rq[k].we && !(e0 || e1);
            if (!rq[k].we) begin
                rd_g = 1'b1;
                exp_q.push_back('{port: k, data: (e0 || e1) ? 32'h0 : ref_rd(rq[k].addr),
                                  cyc: cyc + READ_LAT});
            end else if (!(e0 || e1)) begin
                ref_mem[rq[k].addr] = rq[k].wdata;
            end
            rq[k].act = 1'b0;
        end
        chk("mem_addr", mem_addr_o, ea);
        chk("mem_data", mem_data_o, ed);
        chk("mem_bmode", mem_bmode_o, eb);
        chk("mem_wren", 32'(mem_wren_o), 32'(ew));
        if (g1) begin
            chk("p1_wait_bound", 32'(p1_wait <= MAX_BURST), 32'd1);
            p1_wait = 0;
        end else if (rq[1].act) begin
            p1_wait++;
        end
        @(posedge CLK);
        if (rst) begin
            exp_q.delete();
            hist      = '0;
            p1_passed = 0;
        end else begin
            hist    = hist << 1;
            hist[0] = rd_g;
            if (g1 || !r1_was) p1_passed = 0;
            else if (g0) p1_passed++;
        end
        @(negedge CLK);
    endtask

    task automatic do_req(input int k, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] b);
        set_req(k, we, a, d, b);
        for (int i = 0; i < 16 && rq[k].act; i++) step();
    endtask

    task automatic reset_pulse();
        rq[0].act = 1'b0;
        rq[1].act = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            #3;
            if (rvalid0_o || rvalid1_o) begin
                chk("rvalid_both", 32'(rvalid0_o & rvalid1_o), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid0_o | rvalid1_o), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_port", 32'(rvalid1_o), 32'(mon_e.port));
                    chk("rsp_cycle", cyc, mon_e.cyc);
                    chk("rsp_data", (mon_e.port == 1) ? rdata1_o : rdata0_o, mon_e.data);
                    chk("rsp_other_rdata", (mon_e.port == 1) ? rdata0_o : rdata1_o, 32'h0);
                end
            end else begin
                chk("idle_rdata", rdata0_o | rdata1_o, 32'h0);
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; p1_passed = 0; p1_wait = 0; hist = '0;
        rq[0] = '{act: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, bmode: 32'h0};
        rq[1] = rq[0];
        rst = 1'b1;
        apply();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        step();
        rst = 1'b0;
        repeat (2) step();

        do_req(0, 1'b1, 32'h0004_0010, 32'hDEAD_BEEF, 32'hF);
        do_req(0, 1'b0, 32'h0004_0010, 32'h0, 32'h0);
        do_req(1, 1'b1, 32'h0008_0000, 32'h1234_5678, 32'h2);
        do_req(0, 1'b1, 32'h0010_0000, 32'hCAFE_F00D, 32'h3);
        do_req(0, 1'b0, 32'h0010_0000, 32'h0, 32'h0);
        repeat (READ_LAT + 1) step();

        set_req(0, 1'b0, 32'h0000_0100, 32'h0, 32'h0); step();
        set_req(1, 1'b0, 32'h0008_0000, 32'h0, 32'h0); step();
        set_req(0, 1'b0, 32'h0004_0010, 32'h0, 32'h0); step();
        repeat (READ_LAT + 2) step();

        for (int c = 0; c < 60; c++) begin
            for (int k = 0; k < 2; k++) if (!rq[k].act) rand_req(k);
            step();
        end

        for (int c = 0; c < 3; c++) begin
            set_req(0, 1'b0, 32'h0004_0000 + 32'(4 * c), 32'h0, 32'h0);
            step();
        end
        reset_pulse();
        repeat (READ_LAT + 1) step();

        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!rq[k].act) begin
                    if ($urandom_range(3) == 0) rand_req(k);
                end else if ($urandom_range(15) == 0) begin
                    rq[k].act = 1'b0;
                end
            end
            if (c % 500 == 499) reset_pulse();
            else step();
        end

        rq[0].act = 1'b0;
        rq[1].act = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        chk("drain_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
